shifter_arbiter: RTL

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

---
 rtl/shifter_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester round-robin front end for a shared external
// combinational barrel shifter. Each operation passes through IDLE -> ISSUE -> RESP.
// During ISSUE the registered operands drive the shifter. The shifter result is
// captured into a result register and held until the owning requester takes it.
// Optional feature: define SHIFTER_ARB_ZERO_BYPASS_EN to let zero-amount requests
// skip ISSUE. Their operand is loaded straight into the result register.
module shifter_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_dir,
  input  logic [4:0]  req0_amt,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_dir,
  input  logic [4:0]  req1_amt,
  input  logic [31:0] req1_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        sh_dir,
  output logic [4:0]  sh_amt,
  output logic [31:0] d_in,
  input  logic [31:0] d_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  logic        last_gnt;
  logic        owner;
  logic        op_dir;
  logic [4:0]  op_amt;
  logic [31:0] op_data;
  logic [31:0] result;

  logic        gnt_valid;
  logic        gnt_id;
  logic        sel_dir;
  logic [4:0]  sel_amt;
  logic [31:0] sel_data;
  logic        rsp_hs;

  // Round-robin grant: a lone valid requester wins; on contention the one not served last wins
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid)
      gnt_id = ~last_gnt;
    else if (req1_valid)
      gnt_id = 1'b1;
    sel_dir  = gnt_id ? req1_dir  : req0_dir;
    sel_amt  = gnt_id ? req1_amt  : req0_amt;
    sel_data = gnt_id ? req1_data : req0_data;
    rsp_hs   = owner ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = (state == IDLE) && gnt_valid && !gnt_id;
  assign req1_ready = (state == IDLE) && gnt_valid && gnt_id;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);
  assign rsp_data   = result;
  assign sh_dir     = op_dir;
  assign sh_amt     = op_amt;
  assign d_in       = op_data;

  // Main FSM: accept in IDLE, drive and capture the shifter in ISSUE, hold the result in RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      op_dir   <= 1'b0;
      op_amt   <= 5'd0;
      op_data  <= 32'd0;
      result   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            op_dir   <= sel_dir;
            op_amt   <= sel_amt;
            op_data  <= sel_data;
            owner    <= gnt_id;
            last_gnt <= gnt_id;
`ifdef SHIFTER_ARB_ZERO_BYPASS_EN
            if (sel_amt == 5'd0) begin
              result <= sel_data;
              state  <= RESP;
            end else begin
              state  <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          result <= d_out;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_hs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
